uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Single-channel 8-bit UART with a memory-mapped 32-bit register interface, one-byte TX and RX holding registers, optional parity, and 1 or 2 stop bits.
- Provides CTS/RTS hardware flow control, an RS-485 driver enable, DMA request strobes and one level interrupt.
- Sits behind the system bus bridge and drives the board TX/RX pins.

Parameters:
- DEFAULT_BAUD_DIV, 16'd27, reset value of BAUD register. Clocks per 16x-oversample tick; 27 gives 115200 baud at 50 MHz.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- uart_rxd  in  1  serial input, async, idle high
- uart_txd  out  1  serial output, idle high
- uart_cts_n  in  1  clear-to-send, active low, async
- uart_rts_n  out  1  request-to-send, active low
- uart_de  out  1  RS-485 driver enable
- reg_addr  in  32  byte address; bits [7:0] decoded
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, combinational from reg_addr
- reg_we  in  1  write strobe, one cycle
- reg_re  in  1  read strobe, one cycle; triggers read side effects
- reg_be  in  4  byte enables for writes
- dma_tx_req  out  1  TX holding register empty and TX DMA enabled
- dma_rx_req  out  1  RX byte valid and RX DMA enabled
- intr  out  1  level interrupt

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All registers reset when rst_n is low at a clk edge.
- Reset values:
  - uart_txd=1, uart_rts_n=1, uart_de=0, dma_*=0, intr=0.
  - All CSRs 0, except BAUD=DEFAULT_BAUD_DIV.
  - STATUS reads 0x06 after reset.
- Register map. Unmapped addresses read 0 and ignore writes. Writes honour reg_be per byte lane.
  - 0x00 DATA
    - Write [7:0] loads the TX holding register; the write is ignored if the register is full.
    - Read returns {24'b0, rx_byte}. reg_re at 0x00 clears RX_VALID.
  - 0x04 STATUS
    - bit0 RX_VALID, bit1 TX_EMPTY (holding empty), bit2 TX_IDLE (holding empty and shifter idle).
    - bit3 RX_OVERRUN, bit4 FRAME_ERR, bit5 PARITY_ERR: sticky, write-1-to-clear.
  - 0x08 CR
    - bit0 TX_EN, bit1 RX_EN, bit2 PAR_EN, bit3 PAR_EVEN (1 = even, 0 = odd), bit4 STOP2.
    - bit5 CTS_EN, bit6 DE_EN, bit7 TX_DMA_EN, bit8 RX_DMA_EN.
  - 0x0C BAUD: [15:0] divider. A value of 0 behaves as 1.
  - 0x10 IER: bit0 RX_VALID, bit1 TX_EMPTY, bit2 any error (bits 5:3).
- intr = (IER0 & RX_VALID) | (IER1 & TX_EMPTY) | (IER2 & |STATUS[5:3]). Registered, so it lags by 1 cycle.
- Baud generator:
  - Free-running counter 0..BAUD-1 emits a 1-cycle tick at wrap. One bit period = 16 ticks.
  - A BAUD write restarts the counter.
- TX state machine: IDLE → START → DATA(8, LSB first) → [PARITY] → STOP (1 or 2 bits) → IDLE.
  - Leaves IDLE when TX_EN=1, holding register full, and (CTS_EN=0 or synchronized cts_n=0).
  - The holding register transfers to the shifter on that cycle, and TX_EMPTY sets the next cycle.
  - Clearing TX_EN mid-frame completes the current frame.
  - uart_de=1 from START through the end of STOP when DE_EN=1; otherwise 0.
- RX path:
  - uart_rxd and uart_cts_n pass through 2-FF synchronizers.
  - RX state machine: IDLE → START → DATA → [PARITY] → STOP → IDLE. It leaves IDLE on a falling edge when RX_EN=1.
  - Start is re-checked at tick 8; if high, the start is false and the machine returns to IDLE.
  - Each following bit is sampled every 16 ticks (mid-bit). Only the first stop bit is checked.
  - Stop=0 sets FRAME_ERR. A parity mismatch sets PARITY_ERR. The byte is still delivered in both cases.
  - Byte completes while RX_VALID=1: the new byte is dropped, old byte kept, RX_OVERRUN set.
  - Clearing RX_EN aborts the frame immediately and returns to IDLE.
  - Byte completion and a DATA read in the same cycle: completion wins, so RX_VALID stays 1 with the new byte.
- uart_rts_n = ~(RX_EN & ~RX_VALID), registered.
- DMA requests are levels:
  - dma_tx_req = TX_DMA_EN & TX_EMPTY.
  - dma_rx_req = RX_DMA_EN & RX_VALID.

Decomposition:
- Package uart_pkg:
  - register offset localparams and CR/STATUS/IER bit-index constants;
  - tx_state_t and rx_state_t enums.
- Sub-module uart_baud_gen (counter and tick). TX/RX shifters stay inline.

Test Plan:
- Loopback (txd→rxd), BAUD=27: write CR=0x03, DATA=0xA5, poll STATUS until bit0=1. Read DATA → 0xA5; STATUS bit0=0 after the read; error bits 0.
- Reset: read STATUS → 0x06, BAUD → 27; uart_txd=1 and uart_rts_n=1 throughout reset.
- Parity: CR=0x0F (even parity), send 0x3C → PARITY_ERR=0. Inject a corrupted parity bit on rxd → STATUS bit5=1; write 0x20 to STATUS → bit5 cleared.
- Overrun: send 0x11 then 0x22 without reading → DATA=0x11, RX_OVERRUN=1, uart_rts_n=1 while RX_VALID=1.
- Flow control: CR=0x23, cts_n=1, write DATA=0x55 → txd stays 1 and TX_EMPTY=0. Drop cts_n → frame starts within 3 cycles + 1 tick.
- Interrupt/DMA: IER=0x1, CR |= 0x100, loopback 0x7E → intr=1 and dma_rx_req=1; both drop one cycle after the DATA read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, control/status bit positions and FSM encodings for uart_core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Register offsets (byte addresses, low 8 bits decoded)
  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CR     = 8'h08;
  localparam logic [7:0] ADDR_BAUD   = 8'h0C;
  localparam logic [7:0] ADDR_IER    = 8'h10;

  // CR bit positions
  localparam int CR_TX_EN     = 0;
  localparam int CR_RX_EN     = 1;
  localparam int CR_PAR_EN    = 2;
  localparam int CR_PAR_EVEN  = 3;
  localparam int CR_STOP2     = 4;
  localparam int CR_CTS_EN    = 5;
  localparam int CR_DE_EN     = 6;
  localparam int CR_TX_DMA_EN = 7;
  localparam int CR_RX_DMA_EN = 8;
  localparam int CR_W         = 9;

  // STATUS bit positions
  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_PARITY_ERR = 5;

  // IER bit positions
  localparam int IER_RX_VALID = 0;
  localparam int IER_TX_EMPTY = 1;
  localparam int IER_ERR      = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit that makes the 9-bit word even (even=1) or odd (even=0).
  function automatic logic parity_bit(input logic [7:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-oversample tick generator: free-running counter 0..div-1, one-cycle tick at wrap.
// Latency: tick is combinational from the counter; a restart takes effect the next cycle.
// Backpressure: none, free-running; restart suppresses the tick in its own cycle.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_div_i,
  input  logic        restart_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] last_val;

  // A divider of 0 behaves as 1 (tick every cycle).
  assign last_val = (baud_div_i == 16'd0) ? 16'd0 : (baud_div_i - 16'd1);

  // Use >= so a divider shrinking below the current count still wraps.
  assign tick_o = !restart_i && (cnt_q >= last_val);

  // Next count: restart, wrap, or increment.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart_i || (cnt_q >= last_val)) begin
      cnt_d = 16'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_core.sv
// 8-bit UART with 32-bit CSR port, 1-byte TX/RX holding registers, parity, 1/2 stop, CTS/RTS, RS-485 DE, DMA strobes.
// Latency: CSR reads are combinational; TX starts the cycle after a DATA write; intr/rts/dma outputs are registered (+1 cycle).
// Backpressure: DATA writes are dropped while the TX holding register is full; TX stalls on CTS; RX drops bytes on overrun.
module uart_core
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic        uart_cts_n,
  output logic        uart_rts_n,
  output logic        uart_de,
  input  logic [31:0] reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [3:0]  reg_be,
  output logic        dma_tx_req,
  output logic        dma_rx_req,
  output logic        intr
);

  // ---------------------------------------------------------------- decode
  logic [7:0] addr;
  logic       wr_data, wr_status, wr_cr, wr_baud, wr_ier, rd_data;
  logic       unused_ok;

  assign addr      = reg_addr[7:0];
  assign wr_data   = reg_we && (addr == ADDR_DATA);
  assign wr_status = reg_we && (addr == ADDR_STATUS);
  assign wr_cr     = reg_we && (addr == ADDR_CR);
  assign wr_baud   = reg_we && (addr == ADDR_BAUD);
  assign wr_ier    = reg_we && (addr == ADDR_IER);
  assign rd_data   = reg_re && (addr == ADDR_DATA);
  assign unused_ok = ^{reg_addr[31:8], reg_wdata[31:16], reg_be[3:2]};

  // ---------------------------------------------------------------- CSRs
  logic [CR_W-1:0] cr_q;
  logic [15:0]     baud_q;
  logic [2:0]      ier_q;

  // Control registers with per-lane byte enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_q   <= '0;
      baud_q <= DEFAULT_BAUD_DIV;
      ier_q  <= '0;
    end else begin
      if (wr_cr && reg_be[0])   cr_q[7:0]    <= reg_wdata[7:0];
      if (wr_cr && reg_be[1])   cr_q[8]      <= reg_wdata[8];
      if (wr_baud && reg_be[0]) baud_q[7:0]  <= reg_wdata[7:0];
      if (wr_baud && reg_be[1]) baud_q[15:8] <= reg_wdata[15:8];
      if (wr_ier && reg_be[0])  ier_q        <= reg_wdata[2:0];
    end
  end

  // ---------------------------------------------------------------- baud tick
  logic tick;

  uart_baud_gen u_baud_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div_i (baud_q),
    .restart_i  (wr_baud && (reg_be[0] || reg_be[1])),
    .tick_o     (tick)
  );

  // ---------------------------------------------------------------- synchronizers
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic cts_s1_q, cts_s2_q;

  // Two-flop synchronizers for the async pins, plus a delayed rxd for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      cts_s1_q   <= 1'b1;
      cts_s2_q   <= 1'b1;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      cts_s1_q   <= uart_cts_n;
      cts_s2_q   <= cts_s1_q;
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q,   tx_bit_d;
  logic [3:0] tx_tick_q,  tx_tick_d;
  logic       tx_stop_q,  tx_stop_d;
  logic       tx_par_q,   tx_par_d;
  logic [7:0] tx_hold_q,  tx_hold_d;
  logic       tx_full_q,  tx_full_d;
  logic       txd_q,      txd_d;
  logic       de_q,       de_d;
  logic       cts_ok, tx_go, tx_bit_end;

  assign cts_ok     = !cr_q[CR_CTS_EN] || !cts_s2_q;
  assign tx_go      = (tx_state_q == TX_IDLE) && cr_q[CR_TX_EN] && tx_full_q && cts_ok;
  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  // TX frame sequencing and holding-register handoff; pins are decoded from next state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_tick_d  = tx_tick_q;
    tx_stop_d  = tx_stop_q;
    tx_par_d   = tx_par_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;

    if ((tx_state_q != TX_IDLE) && tick) begin
      tx_tick_d = tx_tick_q + 4'd1;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_go) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_hold_q;
          tx_bit_d   = 3'd0;
          tx_tick_d  = 4'd0;
          tx_stop_d  = 1'b0;
          tx_par_d   = parity_bit(tx_hold_q, cr_q[CR_PAR_EVEN]);
        end
      end
      TX_START: begin
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = cr_q[CR_PAR_EN] ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (cr_q[CR_STOP2] && !tx_stop_q) tx_stop_d = 1'b1;
          else                              tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Handoff frees the holding register; a write only lands when it is empty.
    if (tx_go) begin
      tx_full_d = 1'b0;
    end else if (wr_data && reg_be[0] && !tx_full_q) begin
      tx_hold_d = reg_wdata[7:0];
      tx_full_d = 1'b1;
    end

    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
    de_d = cr_q[CR_DE_EN] && (tx_state_d != TX_IDLE);
  end

  // TX state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 8'd0;
      tx_bit_q   <= 3'd0;
      tx_tick_q  <= 4'd0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_hold_q  <= 8'd0;
      tx_full_q  <= 1'b0;
      txd_q      <= 1'b1;
      de_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_tick_q  <= tx_tick_d;
      tx_stop_q  <= tx_stop_d;
      tx_par_q   <= tx_par_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      txd_q      <= txd_d;
      de_q       <= de_d;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t  rx_state_q, rx_state_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_bit_q,   rx_bit_d;
  logic [3:0] rx_tick_q,  rx_tick_d;
  logic       rx_perr_q,  rx_perr_d;
  logic       rx_done, rx_ferr, rx_mid, rxd, rx_fall;

  assign rxd     = rxd_s2_q;
  assign rx_fall = rxd_prev_q && !rxd_s2_q;
  assign rx_mid  = tick && (rx_tick_q == 4'd15);

  // RX frame sequencing: confirm start at mid-bit, then sample every 16 ticks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_tick_d  = rx_tick_q;
    rx_perr_d  = rx_perr_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;

    if ((rx_state_q != RX_IDLE) && tick) begin
      rx_tick_d = rx_tick_q + 4'd1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (cr_q[CR_RX_EN] && rx_fall) begin
          rx_state_d = RX_START;
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (tick && (rx_tick_q == 4'd7)) begin
          if (rxd) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_tick_d  = 4'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_d = {rxd, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = cr_q[CR_PAR_EN] ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) begin
          rx_perr_d  = (rxd != parity_bit(rx_shift_q, cr_q[CR_PAR_EVEN]));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_done    = 1'b1;
          rx_ferr    = !rxd;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Disabling the receiver abandons any frame in progress.
    if (!cr_q[CR_RX_EN]) begin
      rx_state_d = RX_IDLE;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
    end
  end

  // RX state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_tick_q  <= 4'd0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_tick_q  <= rx_tick_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------------------------------------------------------- RX holding + status
  logic [7:0] rx_data_q;
  logic       rx_valid_q, ovr_q, ferr_q, perr_q;
  logic       rx_accept;
  logic [2:0] err_clr;

  // A same-cycle DATA read frees the slot, so the completing byte is accepted.
  assign rx_accept = rx_done && (!rx_valid_q || rd_data);
  assign err_clr   = (wr_status && reg_be[0]) ? reg_wdata[5:3] : 3'b000;

  // RX holding register and sticky error flags; a new event wins over a W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (rx_accept) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      ovr_q  <= (rx_done && !rx_accept)    || (ovr_q  && !err_clr[0]);
      ferr_q <= (rx_done && rx_ferr)       || (ferr_q && !err_clr[1]);
      perr_q <= (rx_done && rx_perr_q)     || (perr_q && !err_clr[2]);
    end
  end

  // ---------------------------------------------------------------- status / outputs
  logic       tx_empty, tx_idle;
  logic [5:0] status;
  logic       intr_q, rts_n_q, dma_tx_q, dma_rx_q;

  assign tx_empty = !tx_full_q;
  assign tx_idle  = tx_empty && (tx_state_q == TX_IDLE);
  assign status   = {perr_q, ferr_q, ovr_q, tx_idle, tx_empty, rx_valid_q};

  // Registered interrupt, flow-control and DMA levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      intr_q   <= 1'b0;
      rts_n_q  <= 1'b1;
      dma_tx_q <= 1'b0;
      dma_rx_q <= 1'b0;
    end else begin
      intr_q   <= (ier_q[IER_RX_VALID] && rx_valid_q) ||
                  (ier_q[IER_TX_EMPTY] && tx_empty)   ||
                  (ier_q[IER_ERR] && (|status[5:3]));
      rts_n_q  <= !(cr_q[CR_RX_EN] && !rx_valid_q);
      dma_tx_q <= cr_q[CR_TX_DMA_EN] && tx_empty;
      dma_rx_q <= cr_q[CR_RX_DMA_EN] && rx_valid_q;
    end
  end

  assign uart_txd   = txd_q;
  assign uart_de    = de_q;
  assign uart_rts_n = rts_n_q;
  assign intr       = intr_q;
  assign dma_tx_req = dma_tx_q;
  assign dma_rx_req = dma_rx_q;

  // Combinational CSR read mux.
  always_comb begin
    reg_rdata = 32'd0;
    case (addr)
      ADDR_DATA:   reg_rdata = {24'd0, rx_data_q};
      ADDR_STATUS: reg_rdata = {26'd0, status};
      ADDR_CR:     reg_rdata = {{(32-CR_W){1'b0}}, cr_q};
      ADDR_BAUD:   reg_rdata = {16'd0, baud_q};
      ADDR_IER:    reg_rdata = {29'd0, ier_q};
      default:     reg_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: reset, loopback, parity, overrun, CTS flow control, interrupt/DMA.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_core;

  localparam int BIT_CYC = 16 * 27;
  localparam int TMO     = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rxd, uart_txd, uart_cts_n, uart_rts_n, uart_de;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_we, reg_re;
  logic [3:0]  reg_be;
  logic        dma_tx_req, dma_rx_req, intr;
  logic        loop_en, rxd_drv;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  uart_core #(.DEFAULT_BAUD_DIV(16'd27)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .uart_cts_n (uart_cts_n),
    .uart_rts_n (uart_rts_n),
    .uart_de    (uart_de),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_be     (reg_be),
    .dma_tx_req (dma_tx_req),
    .dma_rx_req (dma_rx_req),
    .intr       (intr)
  );

  // ---------------------------------------------------------------- bus helpers
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    reg_addr  = a;
    reg_wdata = d;
    reg_be    = be;
    reg_we    = 1'b1;
    @(posedge clk);
    #1;
    reg_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    reg_addr = a;
    reg_re   = 1'b1;
    #1;
    d = reg_rdata;
    @(posedge clk);
    #1;
    reg_re   = 1'b0;
  endtask

  task automatic wait_status(input int bitn, input int max_cyc, output logic ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      bus_read(32'h04, d);
      if (d[bitn]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_frame(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd_drv = frame[i];
      repeat (BIT_CYC) @(posedge clk);
    end
    #1;
    rxd_drv = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] d;
    logic        ok;
    rst_n = 1'b0;
    cycles(2);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (uart_txd !== 1'b1 || uart_rts_n !== 1'b1) ok = 1'b0;
      cycles(1);
    end
    n_total++; if (ok !== 1'b1) $display("FAIL reset_pins: txd/rts_n not held high (got %b exp 1)", ok); else n_pass++;
    n_total++; if ({uart_de, intr, dma_tx_req, dma_rx_req} !== 4'b0000)
      $display("FAIL reset_outs: de,intr,dma_tx,dma_rx got %b exp 0000", {uart_de, intr, dma_tx_req, dma_rx_req}); else n_pass++;
    rst_n = 1'b1;
    cycles(1);
    bus_read(32'h04, d);
    n_total++; if (d !== 32'h06) $display("FAIL reset_status: got %h exp %h", d, 32'h06); else n_pass++;
    bus_read(32'h0C, d);
    n_total++; if (d !== 32'd27) $display("FAIL reset_baud: got %0d exp 27", d); else n_pass++;
    bus_read(32'h08, d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_cr: got %h exp 0", d); else n_pass++;
    bus_read(32'h20, d);
    n_total++; if (d !== 32'h0) $display("FAIL unmapped_read: got %h exp 0", d); else n_pass++;
    // Byte lane 1 only: just CR bit 8 should land.
    bus_write(32'h08, 32'h0000_FFFF, 4'b0010);
    bus_read(32'h08, d);
    n_total++; if (d !== 32'h100) $display("FAIL cr_byte_enable: got %h exp %h", d, 32'h100); else n_pass++;
    bus_write(32'h08, 32'h0, 4'hF);
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic        ok;
    bus_write(32'h08, 32'h03, 4'hF);
    bus_write(32'h00, 32'hA5, 4'hF);
    wait_status(0, TMO, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL loop_rx_valid: timeout got %b exp 1", ok); else n_pass++;
    bus_read(32'h00, d);
    n_total++; if (d !== 32'hA5) $display("FAIL loop_data: got %h exp %h", d, 32'hA5); else n_pass++;
    bus_read(32'h04, d);
    n_total++; if (d[0] !== 1'b0) $display("FAIL loop_rxv_clear: got %b exp 0", d[0]); else n_pass++;
    n_total++; if (d[5:3] !== 3'b000) $display("FAIL loop_errs: got %b exp 000", d[5:3]); else n_pass++;
    wait_status(2, TMO, ok);
  endtask

  task automatic test_parity();
    logic [31:0] d;
    logic        ok;
    bus_write(32'h08, 32'h0F, 4'hF);
    bus_write(32'h00, 32'h3C, 4'hF);
    wait_status(0, TMO, ok);
    bus_read(32'h04, d);
    n_total++; if (d[5:3] !== 3'b000 || ok !== 1'b1) $display("FAIL par_good: errs got %b exp 000 (rx ok %b)", d[5:3], ok); else n_pass++;
    bus_read(32'h00, d);
    n_total++; if (d !== 32'h3C) $display("FAIL par_good_data: got %h exp %h", d, 32'h3C); else n_pass++;
    wait_status(2, TMO, ok);
    // 0x3C has even weight so the correct even-parity bit is 0; send 1 instead.
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    cycles(4);
    drive_frame({1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    wait_status(0, TMO, ok);
    bus_read(32'h04, d);
    n_total++; if (d[5:3] !== 3'b100) $display("FAIL par_bad_err: got %b exp 100", d[5:3]); else n_pass++;
    bus_read(32'h00, d);
    n_total++; if (d !== 32'h3C) $display("FAIL par_bad_data: got %h exp %h", d, 32'h3C); else n_pass++;
    bus_write(32'h04, 32'h20, 4'hF);
    bus_read(32'h04, d);
    n_total++; if (d[5] !== 1'b0) $display("FAIL par_w1c: got %b exp 0", d[5]); else n_pass++;
    loop_en = 1'b1;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic        ok;
    bus_write(32'h08, 32'h03, 4'hF);
    cycles(3);
    n_total++; if (uart_rts_n !== 1'b0) $display("FAIL ovr_rts_ready: got %b exp 0", uart_rts_n); else n_pass++;
    bus_write(32'h00, 32'h11, 4'hF);
    cycles(3);
    bus_write(32'h00, 32'h22, 4'hF);
    bus_read(32'h04, d);
    n_total++; if (d[1] !== 1'b0) $display("FAIL ovr_hold_full: TX_EMPTY got %b exp 0", d[1]); else n_pass++;
    wait_status(0, TMO, ok);
    cycles(2);
    n_total++; if (uart_rts_n !== 1'b1 || ok !== 1'b1) $display("FAIL ovr_rts_busy: got %b exp 1 (rx ok %b)", uart_rts_n, ok); else n_pass++;
    wait_status(3, TMO, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL ovr_flag: timeout got %b exp 1", ok); else n_pass++;
    bus_read(32'h00, d);
    n_total++; if (d !== 32'h11) $display("FAIL ovr_data_kept: got %h exp %h", d, 32'h11); else n_pass++;
    bus_write(32'h04, 32'h08, 4'hF);
    bus_read(32'h04, d);
    n_total++; if (d[5:0] !== 6'b000_000 && d[5:0] !== 6'b000_110 && d[5:0] !== 6'b000_010)
      $display("FAIL ovr_cleared: status got %b exp errs/rxv 0", d[5:0]); else n_pass++;
    wait_status(2, TMO, ok);
  endtask

  task automatic test_flow_control();
    logic [31:0] d;
    logic        ok;
    int          n;
    uart_cts_n = 1'b1;
    bus_write(32'h08, 32'h23, 4'hF);
    bus_write(32'h00, 32'h55, 4'hF);
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (uart_txd !== 1'b1) ok = 1'b0;
      cycles(1);
    end
    n_total++; if (ok !== 1'b1) $display("FAIL cts_hold_txd: txd moved (got %b exp 1)", ok); else n_pass++;
    bus_read(32'h04, d);
    n_total++; if (d[1] !== 1'b0) $display("FAIL cts_tx_empty: got %b exp 0", d[1]); else n_pass++;
    uart_cts_n = 1'b0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cycles(1);
      if (uart_txd === 1'b0) begin
        n = i;
        break;
      end
    end
    n_total++; if (n == 0 || n > 30) $display("FAIL cts_release: start after %0d cycles, exp 1..30", n); else n_pass++;
    wait_status(0, TMO, ok);
    bus_read(32'h00, d);
    n_total++; if (d !== 32'h55) $display("FAIL cts_data: got %h exp %h", d, 32'h55); else n_pass++;
    wait_status(2, TMO, ok);
  endtask

  task automatic test_intr_dma();
    logic [31:0] d;
    logic        ok;
    bus_write(32'h10, 32'h1, 4'hF);
    bus_write(32'h08, 32'h143, 4'hF);
    cycles(2);
    n_total++; if (intr !== 1'b0) $display("FAIL intr_idle: got %b exp 0", intr); else n_pass++;
    bus_write(32'h00, 32'h7E, 4'hF);
    cycles(5);
    n_total++; if ({uart_de, uart_txd} !== 2'b10) $display("FAIL de_start: de,txd got %b exp 10", {uart_de, uart_txd}); else n_pass++;
    wait_status(0, TMO, ok);
    cycles(2);
    n_total++; if ({intr, dma_rx_req} !== 2'b11) $display("FAIL intr_dma_set: got %b exp 11", {intr, dma_rx_req}); else n_pass++;
    bus_read(32'h00, d);
    n_total++; if (d !== 32'h7E) $display("FAIL intr_data: got %h exp %h", d, 32'h7E); else n_pass++;
    cycles(1);
    n_total++; if ({intr, dma_rx_req} !== 2'b00) $display("FAIL intr_dma_drop: got %b exp 00", {intr, dma_rx_req}); else n_pass++;
    wait_status(2, TMO, ok);
    cycles(1);
    n_total++; if (uart_de !== 1'b0) $display("FAIL de_end: got %b exp 0", uart_de); else n_pass++;
  endtask

  task automatic test_tx_empty_sources();
    bus_write(32'h10, 32'h2, 4'hF);
    cycles(2);
    n_total++; if (intr !== 1'b1) $display("FAIL intr_tx_empty: got %b exp 1", intr); else n_pass++;
    bus_write(32'h08, 32'h80, 4'hF);
    cycles(2);
    n_total++; if (dma_tx_req !== 1'b1) $display("FAIL dma_tx_req: got %b exp 1", dma_tx_req); else n_pass++;
    bus_write(32'h10, 32'h0, 4'hF);
    cycles(2);
    n_total++; if (intr !== 1'b0) $display("FAIL intr_masked: got %b exp 0", intr); else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b0;
    loop_en    = 1'b1;
    rxd_drv    = 1'b1;
    uart_cts_n = 1'b0;
    reg_addr   = 32'h0;
    reg_wdata  = 32'h0;
    reg_we     = 1'b0;
    reg_re     = 1'b0;
    reg_be     = 4'h0;
    test_reset();
    test_loopback();
    test_parity();
    test_overrun();
    test_flow_control();
    test_intr_dma();
    test_tx_empty_sources();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
